// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer and its branch-target LUT.
package fetch_pkg;

  localparam int unsigned DEF_PC_W   = 10;
  localparam int unsigned DEF_LUT_AW = 5;

  localparam logic [DEF_PC_W-1:0] PC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    RUN    = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/branch_lut.sv
// Branch-target table: register array with sync clear, one write port, combinational read.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int unsigned AW = DEF_LUT_AW,
  parameter int unsigned DW = DEF_PC_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: start/arm handshake, branch via LUT,
// halt/overrun detection and a saturating run-cycle counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W   = DEF_PC_W,
  parameter int unsigned LUT_AW = DEF_LUT_AW,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              BranchTaken,
  input  logic [LUT_AW-1:0] BranchIdx,
  input  logic              HaltReq,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutWrAddr,
  input  logic [PC_W-1:0]   LutWrData,
  output logic [PC_W-1:0]   ProgCounter,
  output logic              InstrValid,
  output logic              Done,
  output logic              Overrun,
  output logic [CNT_W-1:0]  CycleCount
);

  localparam logic [PC_W-1:0] PcLast = '1;

  fetch_state_t    state;
  logic [PC_W-1:0] lut_target;
  logic            lut_we;

  // Table is frozen while running so a branch never reads a half-updated entry.
  assign lut_we = LutWe && (state != RUN);

  branch_lut #(
    .AW(LUT_AW),
    .DW(PC_W)
  ) u_branch_lut (
    .clk    (Clk),
    .reset  (Reset),
    .we     (lut_we),
    .wr_addr(LutWrAddr),
    .wr_data(LutWrData),
    .rd_addr(BranchIdx),
    .rd_data(lut_target)
  );

  assign InstrValid = (state == RUN);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      ProgCounter <= '0;
      Done        <= 1'b0;
      Overrun     <= 1'b0;
      CycleCount  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state       <= ARMED;
            ProgCounter <= '0;
            Done        <= 1'b0;
            Overrun     <= 1'b0;
            CycleCount  <= '0;
          end
        end
        ARMED: begin
          ProgCounter <= '0;
          Done        <= 1'b0;
          Overrun     <= 1'b0;
          CycleCount  <= '0;
          if (!Start) state <= RUN;
        end
        RUN: begin
          if (Start) begin
            state       <= ARMED;
            ProgCounter <= '0;
            Done        <= 1'b0;
            Overrun     <= 1'b0;
            CycleCount  <= '0;
          end else begin
            if (CycleCount != '1) CycleCount <= CycleCount + 1'b1;
            if (HaltReq) begin
              state <= HALTED;
              Done  <= 1'b1;
            end else if (BranchTaken) begin
              ProgCounter <= lut_target;
            end else if (ProgCounter == PcLast) begin
              // Falling off the end of ROM stops the run instead of wrapping.
              state   <= HALTED;
              Done    <= 1'b1;
              Overrun <= 1'b1;
            end else begin
              ProgCounter <= ProgCounter + 1'b1;
            end
          end
        end
        HALTED: begin
          if (Start) begin
            state       <= ARMED;
            ProgCounter <= '0;
            Done        <= 1'b0;
            Overrun     <= 1'b0;
            CycleCount  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus hand-written reset/restart sequence.
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       BranchTaken;
  logic [4:0] BranchIdx;
  logic       HaltReq;
  logic       LutWe;
  logic [4:0] LutWrAddr;
  logic [9:0] LutWrData;

  logic [9:0]  pc, pc_s;
  logic        valid, valid_s, done, done_s, ovr, ovr_s;
  logic [15:0] cnt;
  logic [2:0]  cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  fetch_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchTaken(BranchTaken),
    .BranchIdx(BranchIdx), .HaltReq(HaltReq), .LutWe(LutWe),
    .LutWrAddr(LutWrAddr), .LutWrData(LutWrData), .ProgCounter(pc),
    .InstrValid(valid), .Done(done), .Overrun(ovr), .CycleCount(cnt)
  );

  // Narrow counter copy to exercise saturation within a short run.
  fetch_unit #(.PC_W(10), .LUT_AW(5), .CNT_W(3)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BranchTaken(BranchTaken),
    .BranchIdx(BranchIdx), .HaltReq(HaltReq), .LutWe(LutWe),
    .LutWrAddr(LutWrAddr), .LutWrData(LutWrData), .ProgCounter(pc_s),
    .InstrValid(valid_s), .Done(done_s), .Overrun(ovr_s), .CycleCount(cnt_s)
  );

  typedef struct {
    logic        st;
    logic        bt;
    logic [4:0]  idx;
    logic        hr;
    logic        we;
    logic [4:0]  wa;
    logic [9:0]  wd;
    logic [9:0]  pc;
    logic        v;
    logic        d;
    logic        o;
    logic [15:0] c;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic st, logic bt, logic [4:0] idx, logic hr,
                              logic we, logic [4:0] wa, logic [9:0] wd,
                              logic [9:0] epc, logic ev, logic ed, logic eo,
                              logic [15:0] ec);
    vec_t r;
    r.st = st; r.bt = bt; r.idx = idx; r.hr = hr;
    r.we = we; r.wa = wa; r.wd = wd;
    r.pc = epc; r.v = ev; r.d = ed; r.o = eo; r.c = ec;
    vecs.push_back(r);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic bt, input logic [4:0] idx,
                       input logic hr, input logic we, input logic [4:0] wa,
                       input logic [9:0] wd);
    Start = st; BranchTaken = bt; BranchIdx = idx; HaltReq = hr;
    LutWe = we; LutWrAddr = wa; LutWrData = wd;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    check("rst_pc", 32'(pc), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovr", 32'(ovr), 0);
    check("rst_cnt", 32'(cnt), 0);
    Reset = 1'b0;

    // st bt idx hr we wa wd | pc v d o cnt
    add(0, 0, 0, 0, 1, 3, 10'h040,  10'h000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 5, 10'h3FE,  10'h000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,        10'h000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h001, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,        10'h002, 1, 0, 0, 2);
    add(0, 1, 3, 0, 0, 0, 0,        10'h040, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 3, 10'h123,  10'h041, 1, 0, 0, 4);
    add(0, 1, 3, 0, 0, 0, 0,        10'h040, 1, 0, 0, 5);
    add(0, 1, 5, 0, 0, 0, 0,        10'h3FE, 1, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0,        10'h3FF, 1, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0,        10'h3FF, 0, 1, 1, 8);
    add(0, 0, 0, 0, 0, 0, 0,        10'h3FF, 0, 1, 1, 8);
    add(1, 0, 0, 0, 0, 0, 0,        10'h000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 7, 10'h002,  10'h000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h000, 1, 0, 0, 0);
    for (int k = 1; k <= 7; k++) add(0, 0, 0, 0, 0, 0, 0, 10'(k), 1, 0, 0, 16'(k));
    add(0, 0, 0, 1, 0, 0, 0,        10'h007, 0, 1, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0,        10'h007, 0, 1, 0, 8);
    add(1, 0, 0, 0, 0, 0, 0,        10'h000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h000, 1, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 0, 0, 0, 0, 0, 10'(k), 1, 0, 0, 16'(k));
    add(0, 1, 3, 1, 0, 0, 0,        10'h004, 0, 1, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0,        10'h000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h000, 1, 0, 0, 0);
    for (int k = 1; k <= 9; k++) add(0, 0, 0, 0, 0, 0, 0, 10'(k), 1, 0, 0, 16'(k));
    add(1, 1, 3, 1, 0, 0, 0,        10'h000, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h000, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,        10'h001, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,        10'h002, 1, 0, 0, 2);
    add(0, 1, 7, 0, 0, 0, 0,        10'h002, 1, 0, 0, 3);
    add(0, 1, 7, 0, 0, 0, 0,        10'h002, 1, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0,        10'h003, 1, 0, 0, 5);
    add(0, 0, 0, 1, 0, 0, 0,        10'h003, 0, 1, 0, 6);

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].bt, vecs[i].idx, vecs[i].hr,
            vecs[i].we, vecs[i].wa, vecs[i].wd);
      step();
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
      check($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].v));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].d));
      check($sformatf("v%0d_ovr", i), 32'(ovr), 32'(vecs[i].o));
      check($sformatf("v%0d_cnt", i), 32'(cnt), 32'(vecs[i].c));
      check($sformatf("v%0d_satcnt", i), 32'(cnt_s),
            (vecs[i].c > 16'd7) ? 32'd7 : 32'(vecs[i].c));
    end

    // Reset in the middle of a run, then restart; LUT must come back cleared.
    drive(0, 0, 0, 0, 1, 9, 10'h05A); step();
    drive(1, 0, 0, 0, 0, 0, 0);       step();
    drive(0, 0, 0, 0, 0, 0, 0);       step();
    check("mr_run0_pc", 32'(pc), 0);
    drive(0, 1, 9, 0, 0, 0, 0);       step();
    check("mr_branch_pc", 32'(pc), 32'h05A);
    check("mr_branch_valid", 32'(valid), 1);
    Reset = 1'b1;
    drive(1, 1, 9, 1, 1, 9, 10'h111); step();
    Reset = 1'b0;
    check("mr_rst_pc", 32'(pc), 0);
    check("mr_rst_valid", 32'(valid), 0);
    check("mr_rst_done", 32'(done), 0);
    check("mr_rst_cnt", 32'(cnt), 0);
    drive(0, 0, 0, 0, 0, 0, 0);       step();
    check("mr_idle_stays", 32'(valid), 0);
    drive(1, 0, 0, 0, 0, 0, 0);       step();
    check("mr_armed_valid", 32'(valid), 0);
    drive(0, 0, 0, 0, 0, 0, 0);       step();
    check("mr_restart_valid", 32'(valid), 1);
    check("mr_restart_pc", 32'(pc), 0);
    drive(0, 1, 9, 0, 0, 0, 0);       step();
    check("mr_lut_cleared_pc", 32'(pc), 0);
    check("mr_lut_cleared_cnt", 32'(cnt), 1);
    drive(0, 0, 0, 0, 0, 0, 0);       step();
    check("mr_next_pc", 32'(pc), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
